// File: rtl/store_monitor.sv
// Store-bus monitor: logs every store into a show-ahead FIFO and latches a pass/fail/timeout verdict.
// Optional cycle-count timeout is enabled by defining STORE_MONITOR_TIMEOUT_EN.
module store_monitor #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          TIMEOUT    = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [31:0]                  dataadr,
  input  logic [31:0]                  writedata,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [31:0]                  rd_addr,
  output logic [31:0]                  rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TOUT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        mem_addr_q [DEPTH];
  logic [31:0]        mem_addr_d [DEPTH];
  logic [31:0]        mem_data_q [DEPTH];
  logic [31:0]        mem_data_d [DEPTH];

  logic push, pop, full, push_ok;
  logic pass_hit, fail_hit, timeout_hit;

  assign pass_hit = memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign fail_hit = memwrite && !pass_hit && (dataadr != ALLOW_ADDR);

`ifdef STORE_MONITOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  logic [TMR_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_RUN) cyc_d = cyc_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign timeout_hit = (cyc_q == TMR_W'(TIMEOUT - 1));
  assign timeout     = (state_q == ST_TOUT);
`else
  // No counter in this build; TIMEOUT has no influence and the hit is constant 0.
  assign timeout_hit = (TIMEOUT < 0);
  assign timeout     = 1'b0;
`endif

  // A store decision outranks a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (pass_hit)         state_d = ST_PASS;
      else if (fail_hit)    state_d = ST_FAIL;
      else if (timeout_hit) state_d = ST_TOUT;
    end
  end

  always_comb begin
    push       = (state_q == ST_RUN) && memwrite;
    pop        = rd_en && (count_q != '0);
    full       = (count_q == CNT_W'(DEPTH));
    push_ok    = push && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (push_ok) begin
      mem_addr_d[wr_ptr_q] = dataadr;
      mem_data_d[wr_ptr_q] = writedata;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && full && !pop) overflow_d = 1'b1;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign rd_valid = (count_q != '0);
  assign rd_addr  = rd_valid ? mem_addr_q[rd_ptr_q] : 32'd0;
  assign rd_data  = rd_valid ? mem_data_q[rd_ptr_q] : 32'd0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = (state_q != ST_RUN);
  assign pass     = (state_q == ST_PASS);
  assign fail     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_store_monitor.sv
// Randomized + directed bench for store_monitor against a queue-based reference model.
// Works with or without STORE_MONITOR_TIMEOUT_EN defined.
module tb_store_monitor;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 10;
`ifdef STORE_MONITOR_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, memwrite, rd_en;
  logic [31:0] dataadr, writedata;
  logic        rd_valid, overflow, done, pass, fail, timeout;
  logic [31:0] rd_addr, rd_data;
  logic [3:0]  count;

  store_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .overflow(overflow), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic mw, input logic [31:0] a,
                               input logic [31:0] d, input logic rd);
    @(negedge clk);
    reset = r; memwrite = mw; dataadr = a; writedata = d; rd_en = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Reference model: verdict 0=running 1=pass 2=fail 3=timeout; the log is a plain queue.
  bit [63:0] mq[$];
  int        verdict = 0;
  int        cyc = 0;
  bit        ovf = 1'b0;
  bit        model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); verdict = 0; cyc = 0; ovf = 1'b0; model_ok = 1'b1;
    end else if (model_ok && verdict == 0) begin
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (memwrite) begin
        if (mq.size() < DEPTH) mq.push_back({dataadr, writedata});
        else ovf = 1'b1;
      end
      if (memwrite && dataadr == 32'd84 && writedata == 32'd7) verdict = 1;
      else if (memwrite && dataadr != 32'd80)                 verdict = 2;
      else if (TEN && cyc == TIMEOUT - 1)                     verdict = 3;
      cyc++;
    end else if (model_ok) begin
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("rd_valid", rd_valid, mq.size() != 0);
      checkOutput("rd_addr",  rd_addr,  mq.size() != 0 ? mq[0][63:32] : 32'd0);
      checkOutput("rd_data",  rd_data,  mq.size() != 0 ? mq[0][31:0]  : 32'd0);
      checkOutput("count",    count,    mq.size());
      checkOutput("overflow", overflow, ovf);
      checkOutput("done",     done,     verdict != 0);
      checkOutput("pass",     pass,     verdict == 1);
      checkOutput("fail",     fail,     verdict == 2);
      checkOutput("timeout",  timeout,  verdict == 3);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; rd_en = 1'b0;

    // Reset, two logged stores, pass, then drain.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'd80, 32'd5, 0);
    checkOutput("lit_reset_count", count, 0);
    checkOutput("lit_reset_done", done, 0);
    checkOutput("lit_reset_valid", rd_valid, 0);
    applyStimulus(0, 1, 32'd84, 32'd7, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_pass", pass, 1);
    checkOutput("lit_pass_done", done, 1);
    checkOutput("lit_pass_count", count, 2);
    checkOutput("lit_head0_addr", rd_addr, 80);
    checkOutput("lit_head0_data", rd_data, 5);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_head1_addr", rd_addr, 84);
    checkOutput("lit_head1_data", rd_data, 7);
    idle(1);
    checkOutput("lit_drained_valid", rd_valid, 0);
    checkOutput("lit_drained_addr", rd_addr, 0);

    // Wrong data at the pass address fails; later stores are ignored.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'd84, 32'd6, 0);
    applyStimulus(0, 1, 32'd84, 32'd7, 0);
    checkOutput("lit_fail", fail, 1);
    idle(1);
    checkOutput("lit_fail_count", count, 1);
    checkOutput("lit_fail_sticky", pass, 0);

    // Illegal store on the timeout cycle: store decision wins.
    applyStimulus(1, 0, 0, 0, 0);
    idle(9);
    applyStimulus(0, 1, 32'd88, 32'd7, 0);
    idle(1);
    checkOutput("lit_tie_fail", fail, 1);
    checkOutput("lit_tie_timeout", timeout, 0);

    // No stores: timeout in cycle 11 when enabled, never otherwise.
    applyStimulus(1, 0, 0, 0, 0);
    idle(10);
    checkOutput("lit_tout_early", timeout, 0);
    idle(1);
    checkOutput("lit_tout_cycle11", timeout, TEN);
    idle(40);
    checkOutput("lit_tout_late", timeout, TEN);
    checkOutput("lit_tout_done", done, TEN);

    // Fill past DEPTH, then a push that coincides with a pop.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 32'd80, i, 0);
    applyStimulus(0, 1, 32'd80, 32'd100, 1);
    checkOutput("lit_full_count", count, 8);
    checkOutput("lit_overflow", overflow, 1);
    idle(1);
    checkOutput("lit_pushpop_count", count, 8);
    checkOutput("lit_pushpop_head", rd_data, 1);

    // Reset out of PASS with three entries, then pass again.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'd80, 32'd1, 0);
    applyStimulus(0, 1, 32'd80, 32'd2, 0);
    applyStimulus(0, 1, 32'd84, 32'd7, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lit_pre_reset_count", count, 3);
    idle(1);
    checkOutput("lit_post_reset_count", count, 0);
    checkOutput("lit_post_reset_pass", pass, 0);
    checkOutput("lit_post_reset_done", done, 0);
    applyStimulus(0, 1, 32'd84, 32'd7, 0);
    idle(1);
    checkOutput("lit_repass", pass, 1);
    checkOutput("lit_repass_count", count, 1);

    // Random episodes.
    for (int e = 0; e < 60; e++) begin
      int n;
      applyStimulus(1, 0, 0, 0, 0);
      n = $urandom_range(5, 40);
      for (int c = 0; c < n; c++) begin
        int          r;
        logic [31:0] a, d;
        r = $urandom_range(0, 15);
        a = (r < 11) ? 32'd80 : (r < 14) ? 32'd84 : (r == 14) ? 32'd88 : $urandom;
        d = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom_range(0, 15));
        applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, d,
                      $urandom_range(0, 3) == 0);
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable store-bus monitor downstream of the multi-cycle `top` processor; consumes its `memwrite`/`dataadr`/`writedata` data-memory write port. Logs every store into a show-ahead FIFO and latches a pass/fail/timeout verdict. Pass means `PASS_DATA` was stored to `PASS_ADDR`; fail means any store to an address other than `ALLOW_ADDR` that is not the pass store. Replaces the behavioural negedge checker so that FPGA builds and simulation share one checker.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `PASS_ADDR`, 32'd84: terminating store address.
- `PASS_DATA`, 32'd7: required data at `PASS_ADDR`.
- `ALLOW_ADDR`, 32'd80: only other legal store address.
- `TIMEOUT`, 1000: cycles in RUN before the TIMEOUT verdict; ≥1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: store strobe from `top`.
- `dataadr` in 32: store byte address.
- `writedata` in 32: store data.
- `rd_en` in 1: pop FIFO head.
- `rd_valid` out 1: FIFO non-empty.
- `rd_addr` out 32: head entry address.
- `rd_data` out 32: head entry data.
- `count` out $clog2(DEPTH+1): FIFO occupancy.
- `overflow` out 1: sticky; a store was dropped because the FIFO was full.
- `done` out 1: a verdict has been latched.
- `pass` out 1: verdict PASS.
- `fail` out 1: verdict FAIL.
- `timeout` out 1: verdict TIMEOUT.

## Operation
- FSM states: RUN (reset state), PASS, FAIL, TOUT. PASS, FAIL and TOUT are absorbing until `reset`.
- RUN, `memwrite`=1, `dataadr`==PASS_ADDR and `writedata`==PASS_DATA -> PASS.
- RUN, `memwrite`=1, otherwise if `dataadr`!=ALLOW_ADDR -> FAIL. A write to PASS_ADDR with wrong data fails.
- RUN, `memwrite`=1, `dataadr`==ALLOW_ADDR -> stay in RUN.
- Cycle counter: 0 at reset; +1 on every RUN cycle. Sampled value equal to TIMEOUT-1 with no store decision that cycle -> TOUT.
- A store decision in the same cycle as the timeout has priority over the timeout.
- Outputs: `done` = state!=RUN; `pass`/`fail`/`timeout` are one-hot decodes of the state.
- Logging: every `memwrite`=1 cycle in RUN pushes {`dataadr`,`writedata`}, including the verdict-causing store. Stores in terminal states are ignored.
- Push when full: the entry is dropped and `overflow` is set, unless a pop happens in the same cycle, in which case the push succeeds.
- Pop: `rd_en`&&`rd_valid` advances the head. `rd_en` on an empty FIFO is ignored.
- Simultaneous push and pop on a non-empty FIFO: `count` is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately, with range 0..DEPTH.
- The FIFO stays drainable after a verdict.

## Timing
- Reset, synchronous on the edge where `reset`=1: state=RUN, counter=0, FIFO empty, and `rd_valid`, `count`, `overflow`, `done`, `pass`, `fail`, `timeout` all 0. `rd_addr`/`rd_data` read 0 while empty.
- `reset` asserted mid-run or post-verdict has the same effect and discards FIFO contents.
- Verdict latency: store sampled at edge N -> verdict outputs high after edge N, i.e. visible in cycle N+1.
- Push latency: store at edge N -> `rd_valid`/`count` updated after edge N. Show-ahead: head data is valid combinationally from FIFO RAM/regs whenever `rd_valid`=1.
- Pop: head advances at the `rd_en` edge; the next entry appears the following cycle.
- Timeout: with `reset` released at edge 0, TOUT is reached after edge TIMEOUT if no store decides earlier.

## Configuration
- `STORE_MONITOR_TIMEOUT_EN` defined: cycle counter and TOUT state are present, behaving as above.
- `STORE_MONITOR_TIMEOUT_EN` undefined: no counter is instantiated, TOUT is unreachable, `timeout` is tied 0, and `TIMEOUT` is ignored. RUN persists until a store decides the verdict.

## Test plan
- Reset 2 cycles, then store (80,5), then (84,7) -> after the second edge: `pass`=1, `done`=1, `count`=2, FIFO pops (80,5) then (84,7), `rd_valid`=0.
- Store (84,6) -> `fail`=1; a subsequent (84,7) does not push (`count` stays 1) and does not change the verdict.
- Store (88,7) in the same cycle the counter hits TIMEOUT-1 -> `fail`=1, `timeout`=0.
- With the macro defined and TIMEOUT=10, no stores -> `timeout`=1 in cycle 11. Without the macro -> `timeout` stays 0 after 50 cycles.
- DEPTH=8: 9 stores to 80 with no pops -> `count`=8, `overflow`=1. A 10th store with `rd_en`=1 that cycle -> accepted, `count` stays 8.
- Assert `reset` for 1 cycle while in PASS with 3 logged entries -> next cycle all outputs 0 and state RUN; (84,7) then passes again.
